// File: rtl/rx_iq_fetch.sv
// rx_iq_fetch: drains the rx ADC CDC FIFO (FWFT, 4xIQ words).
// After each enable it discards a short burst of stale words, then picks one
// antenna. It removes DC per component with a running average and emits a
// registered single-antenna {Q,I} sample stream.
module rx_iq_fetch #(
    parameter int IQ_DATA_WIDTH = 16,
    parameter int DC_SHIFT      = 4,
    parameter int FLUSH_LEN     = 8
) (
    input  logic                       acc_clk,
    input  logic                       acc_rstn,
    input  logic                       enable,
    input  logic                       ant_sel,
    input  logic                       dc_bypass,
    input  logic [4*IQ_DATA_WIDTH-1:0] data_from_fifo,
    input  logic                       emptyn_from_fifo,
    output logic                       fifo_rd_en,
    output logic [2*IQ_DATA_WIDTH-1:0] sample_iq,
    output logic                       sample_valid,
    output logic [31:0]                sample_count,
    output logic [1:0]                 fetch_state
);

    localparam int IQW  = IQ_DATA_WIDTH;
    localparam int ACCW = IQ_DATA_WIDTH + DC_SHIFT;

    // Clamp limits for the difference, expressed at accumulator width
    localparam logic signed [ACCW-1:0] SAT_MAX = {{(DC_SHIFT + 1){1'b0}}, {(IQW - 1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(DC_SHIFT + 1){1'b1}}, {(IQW - 1){1'b0}}};
    localparam logic [7:0]             FLUSH_LAST = 8'(FLUSH_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t              state_q;
    logic [7:0]          flush_cnt_q;
    logic [2*IQW-1:0]    sample_iq_q;
    logic                sample_valid_q;
    logic [31:0]         sample_count_q;

    logic                acc_clr;
    logic                run_pop;
    logic [2*IQW-1:0]    result;

    // Pop strobe: only in FLUSH/RUN, only with data present, never during reset
    always_comb begin
        fifo_rd_en = 1'b0;
        if (acc_rstn && enable && emptyn_from_fifo &&
            (state_q == ST_FLUSH || state_q == ST_RUN)) begin
            fifo_rd_en = 1'b1;
        end
    end

    // A fresh enable clears the DC history; only RUN pops feed the averager
    assign acc_clr = (state_q == ST_IDLE) && enable;
    assign run_pop = (state_q == ST_RUN) && fifo_rd_en;

    // Per-component DC removal: gi=0 handles I, gi=1 handles Q
    for (genvar gi = 0; gi < 2; gi++) begin : g_dc
        logic signed [IQW-1:0]  x;
        logic signed [IQW-1:0]  y_sat;
        logic signed [ACCW-1:0] acc_q;
        logic signed [ACCW-1:0] acc_d;
        logic signed [ACCW-1:0] dc;
        logic signed [ACCW-1:0] diff;

        assign x    = ant_sel ? data_from_fifo[(2 + gi)*IQW +: IQW]
                              : data_from_fifo[gi*IQW +: IQW];
        assign dc   = acc_q >>> DC_SHIFT;
        assign diff = {{DC_SHIFT{x[IQW-1]}}, x} - dc;
        // The leaky average keeps acc bounded, so this sum cannot overflow
        assign acc_d = acc_q + diff;

        // Clamp the DC-corrected value back into IQW signed range
        always_comb begin
            if (diff > SAT_MAX) begin
                y_sat = SAT_MAX[IQW-1:0];
            end else if (diff < SAT_MIN) begin
                y_sat = SAT_MIN[IQW-1:0];
            end else begin
                y_sat = diff[IQW-1:0];
            end
        end

        assign result[gi*IQW +: IQW] = dc_bypass ? x : y_sat;

        // Running accumulator, updated on every RUN pop regardless of bypass
        always_ff @(posedge acc_clk) begin
            if (!acc_rstn || acc_clr) begin
                acc_q <= '0;
            end else if (run_pop) begin
                acc_q <= acc_d;
            end
        end
    end

    // Fetch FSM with registered sample outputs
    always_ff @(posedge acc_clk) begin
        if (!acc_rstn) begin
            state_q        <= ST_IDLE;
            flush_cnt_q    <= '0;
            sample_iq_q    <= '0;
            sample_valid_q <= 1'b0;
            sample_count_q <= '0;
        end else begin
            sample_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q        <= ST_FLUSH;
                        flush_cnt_q    <= '0;
                        sample_count_q <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (!enable) begin
                        state_q <= ST_IDLE;
                    end else if (fifo_rd_en) begin
                        flush_cnt_q <= flush_cnt_q + 8'd1;
                        if (flush_cnt_q == FLUSH_LAST) begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_q <= ST_IDLE;
                    end else if (fifo_rd_en) begin
                        sample_iq_q    <= result;
                        sample_valid_q <= 1'b1;
                        sample_count_q <= sample_count_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sample_iq    = sample_iq_q;
    assign sample_valid = sample_valid_q;
    assign sample_count = sample_count_q;
    assign fetch_state  = state_q;

endmodule

// File: tb/tb_rx_iq_fetch.sv
// Testbench for rx_iq_fetch. Random and directed FIFO traffic is checked
// against a behavioural model of the fetch/flush/DC-removal rules.
module tb_rx_iq_fetch;

    localparam int IQW  = 16;
    localparam int DCS  = 4;
    localparam int FLEN = 8;

    logic        acc_clk = 1'b0;
    logic        acc_rstn = 1'b0;
    logic        enable = 1'b0;
    logic        ant_sel = 1'b0;
    logic        dc_bypass = 1'b0;
    logic [63:0] data_from_fifo = '0;
    logic        emptyn_from_fifo = 1'b0;
    logic        fifo_rd_en;
    logic [31:0] sample_iq;
    logic        sample_valid;
    logic [31:0] sample_count;
    logic [1:0]  fetch_state;

    rx_iq_fetch #(
        .IQ_DATA_WIDTH(IQW),
        .DC_SHIFT     (DCS),
        .FLUSH_LEN    (FLEN)
    ) dut (
        .acc_clk         (acc_clk),
        .acc_rstn        (acc_rstn),
        .enable          (enable),
        .ant_sel         (ant_sel),
        .dc_bypass       (dc_bypass),
        .data_from_fifo  (data_from_fifo),
        .emptyn_from_fifo(emptyn_from_fifo),
        .fifo_rd_en      (fifo_rd_en),
        .sample_iq       (sample_iq),
        .sample_valid    (sample_valid),
        .sample_count    (sample_count),
        .fetch_state     (fetch_state)
    );

    always #5 acc_clk = ~acc_clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          prev_en = 1'b0;   // enable was seen high (out of reset) at the last edge
    int          flush_pops = 0;   // words popped since the last enable rise
    int          acc_i = 0;
    int          acc_q = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_iq = '0;
    logic [31:0] m_count = '0;
    int          m_state = 0;

    // FIFO head emulation
    logic [63:0] head = '0;
    bit          need_new = 1'b1;
    int          words_left = -1;  // -1 means unlimited supply
    int          mode = 0;         // 0 random words, 1 constant I on both antennas
    logic [15:0] cval = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int floor_div(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // DC removal of one component; returns output value and updates the accumulator
    function automatic int dc_remove(input int x, inout int acc, input bit byp);
        int dc;
        int y;
        dc  = floor_div(acc, 1 << DCS);
        y   = clamp16(x - dc);
        acc = acc + x - dc;
        return byp ? x : y;
    endfunction

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // Apply the block's rules to what happened at this clock edge
    task automatic model_update(input bit pop);
        int xi, xq, oi, oq;
        logic [15:0] oi16, oq16;
        if (!acc_rstn) begin
            prev_en = 1'b0; flush_pops = 0; acc_i = 0; acc_q = 0;
            m_valid = 1'b0; m_iq = '0; m_count = '0; m_state = 0;
            return;
        end
        m_valid = 1'b0;
        if (enable && !prev_en) begin
            flush_pops = 0; acc_i = 0; acc_q = 0; m_count = '0;
        end
        if (pop) begin
            if (flush_pops < FLEN) begin
                flush_pops++;
            end else begin
                xi = ant_sel ? s16(head[47:32]) : s16(head[15:0]);
                xq = ant_sel ? s16(head[63:48]) : s16(head[31:16]);
                oi = dc_remove(xi, acc_i, dc_bypass);
                oq = dc_remove(xq, acc_q, dc_bypass);
                oi16 = 16'(oi);
                oq16 = 16'(oq);
                m_iq = {oq16, oi16};
                m_valid = 1'b1;
                m_count = m_count + 32'd1;
            end
        end
        if (!enable)                m_state = 0;
        else if (!prev_en)          m_state = 1;
        else if (flush_pops < FLEN) m_state = 1;
        else                        m_state = 2;
        prev_en = enable;
    endtask

    // One clock cycle: drive at negedge, check pop strobe, model the edge, check outputs
    task automatic step(input bit en, input bit rstn, input bit empt);
        bit exp_pop;
        enable = en;
        acc_rstn = rstn;
        emptyn_from_fifo = empt;
        if (need_new) begin
            if (mode == 0) head = {$urandom, $urandom};
            else           head = {16'h0000, cval, 16'h0000, cval};
            need_new = 1'b0;
        end
        data_from_fifo = head;
        #1;
        exp_pop = rstn && en && prev_en && empt;
        check_val("rd_en", {63'd0, fifo_rd_en}, {63'd0, exp_pop});
        @(posedge acc_clk);
        model_update(exp_pop);
        if (exp_pop) begin
            need_new = 1'b1;
            if (words_left > 0) words_left--;
        end
        @(negedge acc_clk);
        check_val("valid", {63'd0, sample_valid}, {63'd0, m_valid});
        check_val("iq",    {32'd0, sample_iq},    {32'd0, m_iq});
        check_val("count", {32'd0, sample_count}, {32'd0, m_count});
        check_val("state", {62'd0, fetch_state},  64'(m_state));
    endtask

    initial begin
        int prev_i;
        bit seen;
        @(negedge acc_clk);

        // Reset, then 10 words: 8 flushed, 2 emitted
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_val("rst_iq", {32'd0, sample_iq}, 64'd0);
        check_val("rst_state", {62'd0, fetch_state}, 64'd0);
        words_left = 10;
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1, words_left > 0);
        check_val("t1_count", {32'd0, sample_count}, 64'd2);
        check_val("t1_state", {62'd0, fetch_state}, 64'd2);
        $display("phase 1 flush-then-run: count=%0d state=%0d", sample_count, fetch_state);
        words_left = -1;

        // Bypass, antenna 1, I1=100 Q1=-50
        dc_bypass = 1'b1; ant_sel = 1'b1;
        head = {16'hFFCE, 16'd100, $urandom}; need_new = 1'b0;
        step(1'b1, 1'b1, 1'b1);
        check_val("t2_iq", {32'd0, sample_iq}, {32'd0, 16'hFFCE, 16'h0064});
        $display("phase 2 bypass ant1: iq=0x%08h", sample_iq);

        // Constant I=1000 with DC removal after a re-flush
        dc_bypass = 1'b0; ant_sel = 1'b0; mode = 1; cval = 16'd1000;
        step(1'b0, 1'b1, 1'b1);
        need_new = 1'b1;
        seen = 1'b0; prev_i = 0;
        for (int i = 0; i < 430; i++) begin
            step(1'b1, 1'b1, 1'b1);
            if (sample_valid) begin
                if (!seen) check_val("t3_first", {48'd0, sample_iq[15:0]}, 64'd1000);
                else       check_val("t3_mono", {63'd0, s16(sample_iq[15:0]) <= prev_i}, 64'd1);
                seen = 1'b1;
                prev_i = s16(sample_iq[15:0]);
            end
        end
        check_val("t3_small", {63'd0, (prev_i >= -1) && (prev_i <= 1)}, 64'd1);
        $display("phase 3 dc convergence: last I=%0d", prev_i);

        // Saturation: long positive full scale then negative full scale
        cval = 16'h7FFF;
        for (int i = 0; i < 420; i++) step(1'b1, 1'b1, 1'b1);
        cval = 16'h8000;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        check_val("t4_sat", {48'd0, sample_iq[15:0]}, {48'd0, 16'h8000});
        $display("phase 4 saturation: I=0x%04h", sample_iq[15:0]);

        // emptyn toggling, then enable drop
        mode = 0;
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, i[0]);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
        check_val("t5_idle", {62'd0, fetch_state}, 64'd0);
        $display("phase 5 toggling and disable: state=%0d", fetch_state);

        // One-cycle reset during RUN
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check_val("t6_state", {62'd0, fetch_state}, 64'd0);
        check_val("t6_valid", {63'd0, sample_valid}, 64'd0);
        check_val("t6_iq", {32'd0, sample_iq}, 64'd0);
        $display("phase 6 reset mid-run: state=%0d", fetch_state);

        // Random traffic with occasional enable drops and resets
        for (int i = 0; i < 3000; i++) begin
            ant_sel   = 1'($urandom_range(0, 1));
            dc_bypass = 1'($urandom_range(0, 1));
            step($urandom_range(0, 49) != 0, $urandom_range(0, 299) != 0,
                 $urandom_range(0, 3) != 0);
        end
        $display("phase 7 random traffic: samples since last enable=%0d", sample_count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
